// File: rtl/block_shift_arb_pkg.sv
// Shared helpers for the block_shift_arb scheduler: widths, switch values, response record.
// No logic lives here; everything is elaborated at compile time.
// Not applicable (no handshakes in a package).
`ifndef BLOCK_SHIFT_ARB_SWITCHES
`define BLOCK_SHIFT_ARB_SWITCHES
`define Enable 1'b1
`define Disable 1'b0
`endif

package block_shift_arb_pkg;

  // Default configuration of the scheduler
  localparam int NUM_REQS = 4;
  localparam int NUM_ELMS = 8;
  localparam int ELM_BITS = 8;

  // Shift amount must be able to express 0..ELMS inclusive
  function automatic int shamt_w(input int elms);
    return $clog2(elms + 1);
  endfunction

  // Requester index width, never narrower than one bit
  function automatic int req_id_w(input int reqs);
    return (reqs > 2) ? $clog2(reqs) : 1;
  endfunction

  localparam int NUM_SHAMT  = shamt_w(NUM_ELMS);
  localparam int NUM_REQ_ID = req_id_w(NUM_REQS);

  // One result as seen on the response channel of the default configuration
  typedef struct packed {
    logic [NUM_REQ_ID-1:0]              id;
    logic [NUM_ELMS-1:0][ELM_BITS-1:0]  data;
  } resp_t;

endpackage

// File: rtl/block_shift.sv
// Element-granular shifter/rotator over an ELMS x DATA vector.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module block_shift #(
  parameter int ELMS     = 8,
  parameter int DATA     = 8,
  parameter bit ROTATE   = 1'b0,
  parameter bit TO_RIGHT = 1'b0,
  parameter int SHAMT    = $clog2(ELMS + 1)
) (
  input  logic [ELMS-1:0][DATA-1:0] in_i,
  input  logic [SHAMT-1:0]          shamt_i,
  output logic [ELMS-1:0][DATA-1:0] out_o
);

  int s;
  int s_mod;
  int src;

  // Each output element picks its source element; out-of-range sources give zero fill
  always_comb begin
    out_o = '0;
    s     = int'(shamt_i);
    s_mod = s % ELMS;
    src   = 0;
    for (int i = 0; i < ELMS; i++) begin
      if (ROTATE) begin
        src = TO_RIGHT ? (i + s_mod) % ELMS : (i - s_mod + ELMS) % ELMS;
      end else begin
        src = TO_RIGHT ? i + s : i - s;
      end
      for (int k = 0; k < ELMS; k++) begin
        if (k == src) begin
          out_o[i] = in_i[k];
        end
      end
    end
  end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant plus binary index, searching upward from a pointer.
// Latency: grant is combinational; pointer advances on the granting edge.
// Backpressure: en_i low suppresses the grant and freezes the pointer.
module rr_arb
  import block_shift_arb_pkg::*;
#(
  parameter int REQS   = NUM_REQS,
  parameter int REQ_ID = req_id_w(REQS)
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [REQS-1:0]   req_i,
  input  logic              en_i,
  output logic [REQS-1:0]   grant_o,
  output logic [REQ_ID-1:0] grant_id_o
);

  logic [REQ_ID-1:0] ptr_q, ptr_d;
  logic [REQS-1:0]   req_rot;
  logic              found;
  int                sum;

  // Rotate requests so the pointer lands on bit 0, then take the lowest set bit
  always_comb begin
    req_rot    = REQS'({req_i, req_i} >> ptr_q);
    found      = 1'b0;
    grant_id_o = '0;
    sum        = 0;
    for (int k = 0; k < REQS; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        sum   = int'(ptr_q) + k;
        if (sum >= REQS) begin
          sum = sum - REQS;
        end
        grant_id_o = REQ_ID'(sum);
      end
    end
  end

  // Decode the winner to one-hot and compute the pointer just past it
  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    if (en_i && found) begin
      for (int j = 0; j < REQS; j++) begin
        grant_o[j] = (REQ_ID'(j) == grant_id_o);
      end
      ptr_d = (int'(grant_id_o) == REQS - 1) ? '0 : grant_id_o + REQ_ID'(1);
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/block_shift_arb.sv
// Time-shares one block_shift among REQS requesters, result returned in a tagged register.
// Latency: 1 cycle from accepting edge to resp_valid; 1 result/cycle while resp_ready=1.
// Backpressure: a held, unconsumed result blocks all grants and freezes the arbiter.
module block_shift_arb
  import block_shift_arb_pkg::*;
#(
  parameter int REQS     = NUM_REQS,
  parameter int ELMS     = NUM_ELMS,
  parameter int DATA     = ELM_BITS,
  parameter bit ROTATE   = `Disable,
  parameter bit TO_RIGHT = `Disable,
  parameter int SHAMT    = shamt_w(ELMS),
  parameter int REQ_ID   = req_id_w(REQS)
) (
  input  logic                              clk,
  input  logic                              reset_,
  input  logic [REQS-1:0]                   req_valid,
  output logic [REQS-1:0]                   req_ready,
  input  logic [REQS-1:0][ELMS-1:0][DATA-1:0] req_data,
  input  logic [REQS-1:0][SHAMT-1:0]        req_shamt,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [REQ_ID-1:0]                 resp_id,
  output logic [ELMS-1:0][DATA-1:0]         resp_data,
  output logic                              busy
);

  typedef struct packed {
    logic [REQ_ID-1:0]          id;
    logic [ELMS-1:0][DATA-1:0]  data;
  } resp_q_t;

  logic                      resp_valid_q, resp_valid_d;
  resp_q_t                   resp_q, resp_d;
  logic                      slot_free;
  logic [REQS-1:0]           grant;
  logic [REQ_ID-1:0]         grant_id;
  logic [ELMS-1:0][DATA-1:0] sel_data;
  logic [SHAMT-1:0]          sel_shamt;
  logic [SHAMT-1:0]          shamt_n;
  logic [ELMS-1:0][DATA-1:0] shifted;

  // The result slot can take a new value if empty or being drained this cycle
  assign slot_free = !resp_valid_q || resp_ready;

  rr_arb #(
    .REQS   (REQS),
    .REQ_ID (REQ_ID)
  ) u_arb (
    .clk        (clk),
    .reset_     (reset_),
    .req_i      (req_valid),
    .en_i       (slot_free),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  assign req_ready = grant;

  // Steer the winning requester's operands onto the shared shifter
  always_comb begin
    sel_data  = '0;
    sel_shamt = '0;
    for (int r = 0; r < REQS; r++) begin
      if (REQ_ID'(r) == grant_id) begin
        sel_data  = req_data[r];
        sel_shamt = req_shamt[r];
      end
    end
  end

  // Fold out-of-range shift amounts: modulo for rotate, saturate for shift
  always_comb begin
    shamt_n = sel_shamt;
    if (ROTATE) begin
      shamt_n = SHAMT'(int'(sel_shamt) % ELMS);
    end else if (int'(sel_shamt) > ELMS) begin
      shamt_n = SHAMT'(ELMS);
    end
  end

  block_shift #(
    .ELMS     (ELMS),
    .DATA     (DATA),
    .ROTATE   (ROTATE),
    .TO_RIGHT (TO_RIGHT),
    .SHAMT    (SHAMT)
  ) u_shift (
    .in_i    (sel_data),
    .shamt_i (shamt_n),
    .out_o   (shifted)
  );

  // Load on grant (drain-and-load keeps valid high); drain alone clears valid, data holds
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    if (|grant) begin
      resp_valid_d = 1'b1;
      resp_d.id    = grant_id;
      resp_d.data  = shifted;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // Response register; reset discards any held result immediately
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_q.id;
  assign resp_data  = resp_q.data;
  assign busy       = resp_valid_q | (|req_valid);

endmodule

// File: doc/block_shift_arb.md
Name: block_shift_arb

Overview:
- Round-robin scheduler that time-shares one block_shift datapath among REQS independent requesters.
- Each requester presents an element vector and a shift amount over a valid/ready handshake.
- The block arbitrates, applies the shared block_shift, and returns the result through a single registered response channel tagged with the requester index.
- Sits between the issue logic of several client units and one physical shifter, so the ELMS×DATA crossbar is not duplicated per client.

Parameters:
- REQS, 4, number of requesters (≥2)
- ELMS, 8, elements per vector
- DATA, 8, bits per element
- ROTATE, `Disable, forwarded to block_shift: rotate instead of shift
- TO_RIGHT, `Disable, forwarded to block_shift: shift/rotate toward element 0
- SHAMT, $clog2(ELMS+1), shift-amount width
- REQ_ID, $clog2(REQS), requester index width

Ports:
- clk, in, 1, clock
- reset_, in, 1, asynchronous active-low reset
- req_valid, in, [REQS-1:0], request present per requester
- req_ready, out, [REQS-1:0], request accepted this cycle (one-hot or zero)
- req_data, in, [REQS-1:0][ELMS-1:0][DATA-1:0], operand vector per requester
- req_shamt, in, [REQS-1:0][SHAMT-1:0], shift amount per requester
- resp_valid, out, 1, result register holds a valid result
- resp_ready, in, 1, consumer accepts the result
- resp_id, out, REQ_ID, index of the requester that produced the result
- resp_data, out, [ELMS-1:0][DATA-1:0], shifted/rotated vector
- busy, out, 1, resp_valid OR any req_valid

Behaviour:
- Clock and reset: one clock, clk. reset_ is asynchronous and active-low.
- Reset values: resp_valid=0, resp_id=0, resp_data=0, round-robin pointer=0. req_ready follows reset state combinationally.
- Slot free: slot_free = !resp_valid || resp_ready.
- Grant:
  - Grant only when slot_free and |req_valid.
  - Winner is the first requester with req_valid set, searching upward from pointer and wrapping modulo REQS.
  - req_ready[winner]=1; all other bits are 0.
  - req_ready is combinational from req_valid, pointer and slot_free.
- Pointer update: on a grant, pointer <= winner+1, wrapping to 0 after REQS-1. With no grant, pointer holds.
- Fairness: a requester holding req_valid is granted within REQS grants.
- Shift-amount normalisation, applied before block_shift:
  - ROTATE=`Disable: shamt > ELMS saturates to ELMS, giving an all-zero result.
  - ROTATE=`Enable: shamt is reduced modulo ELMS (shamt=ELMS yields identity).
  - The normaliser is combinational, with no added latency.
- Datapath: the muxed winner operand feeds a single block_shift instance. Its output is captured into resp_data on the grant edge, with resp_id <= winner and resp_valid <= 1.
- Latency: exactly 1 cycle from the accepting edge to resp_valid.
- Throughput: 1 result/cycle while resp_ready=1.
- Back-pressure: with resp_valid=1 and resp_ready=0:
  - no grant is issued;
  - resp_data and resp_id are held stable;
  - the pointer holds.
- Simultaneous drain and grant: resp_ready=1 and a pending request in the same cycle → new result loaded, resp_valid stays 1 (no bubble).
- Drain without grant: resp_ready=1 and no request → resp_valid <= 0; resp_data holds its last value.
- Requester rules:
  - A requester must hold req_data and req_shamt stable while req_valid=1 and req_ready=0.
  - Dropping req_valid before a grant is permitted (no side effect).
- Mid-operation reset: asserting reset_ discards any held result immediately (asynchronously). Pending requests are re-arbitrated from pointer 0 after release.

Decomposition:
- Shared package block_shift_arb_pkg:
  - localparam helpers for SHAMT/REQ_ID width computation (REQ_ID minimum 1);
  - typedef of the response struct {id, data}, used by both RTL and bench.
- Sub-module rr_arb:
  - parameter REQS;
  - inputs req, en;
  - outputs one-hot grant, binary grant_id;
  - holds the pointer internally.
- block_shift is instantiated unmodified.

Test Plan:
- Single requester 0, data elm[i]=i+1, shamt=3, ROTATE=0, TO_RIGHT=0 → next cycle resp_valid=1, resp_id=0, resp_data elms[7:0]=5,4,3,2,1,0,0,0.
- All 4 requesters valid continuously, resp_ready=1 → grants 0,1,2,3,0,… on consecutive cycles, with resp_id matching one cycle later and no bubbles.
- Requesters 1 and 3 valid, resp_ready held 0 for 5 cycles after the first result → req_ready=0 and resp_data/resp_id stable throughout. After release, grant order is 3 then 1.
- Overrange shamt:
  - shift build, shamt=12, ELMS=8 → resp_data=0.
  - rotate build, shamt=8 → resp_data=input.
  - rotate build, shamt=10 → equals rotate by 2.
- Reset pulse while resp_valid=1 with requests pending → resp_valid=0 asynchronously. After release, the first grant goes to the lowest-index valid requester.
- Randomised 1000-cycle run against a reference model (the same shift/rotate equations as the block_shift check) → every response is correct, in order per requester, and no requester waits more than REQS grants.
